// File: rtl/seg7_bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaled tick, single-step, parallel load,
// and a time-multiplexed seven-segment scan with optional leading-zero blanking.
module seg7_bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10000000,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  cnt_en,
  input  logic                  up,
  input  logic                  step,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] TICK_HALF = PW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]          presc_r;
  logic [SW-1:0]          scan_cnt_r;
  logic [IW-1:0]          scan_idx_r;
  logic                   tick_s;
  logic                   event_s;
  logic                   carry_s;
  logic                   borrow_s;
  logic                   zero_run_s;
  logic [4*DIGITS-1:0]    inc_s;
  logic [4*DIGITS-1:0]    dec_s;
  logic [4*DIGITS-1:0]    load_clamp_s;
  logic [DIGITS-1:0]      blank_s;
  logic [DIGITS-1:0]      sel_s;
  logic [3:0]             cur_digit_s;
  logic                   blank_cur_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Next-count candidates (ripple carry/borrow), load clamping, blanking and scan decode
  always_comb begin
    tick_s     = cnt_en && (presc_r == TICK_LAST);
    event_s    = tick_s || step;
    carry_s    = 1'b1;
    borrow_s   = 1'b1;
    zero_run_s = 1'b1;
    inc_s        = '0;
    dec_s        = '0;
    load_clamp_s = '0;
    blank_s      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamp_s[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
      inc_s[4*i +: 4] = carry_s
          ? ((count_bcd[4*i +: 4] == 4'd9) ? 4'd0 : count_bcd[4*i +: 4] + 4'd1)
          : count_bcd[4*i +: 4];
      dec_s[4*i +: 4] = borrow_s
          ? ((count_bcd[4*i +: 4] == 4'd0) ? 4'd9 : count_bcd[4*i +: 4] - 4'd1)
          : count_bcd[4*i +: 4];
      carry_s  = carry_s && (count_bcd[4*i +: 4] == 4'd9);
      borrow_s = borrow_s && (count_bcd[4*i +: 4] == 4'd0);
    end
    // A digit blanks when it and every more-significant digit are zero
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (count_bcd[4*i +: 4] == 4'd0);
      blank_s[i] = (BLANK_LZ != 0) && (i != 0) && zero_run_s;
    end
    cur_digit_s = count_bcd[{scan_idx_r, 2'b00} +: 4];
    blank_cur_s = blank_s[scan_idx_r];
    sel_s       = DIGITS'(1'b1) << scan_idx_r;
  end

  // Prescaler, count, scan position and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r    <= '0;
      scan_cnt_r <= '0;
      scan_idx_r <= '0;
      count_bcd  <= '0;
      wrap       <= 1'b0;
      segments   <= 7'h00;
      dp         <= 1'b0;
      digit_sel  <= '0;
    end else if (ena) begin
      if (scan_cnt_r == SCAN_LAST) begin
        scan_cnt_r <= '0;
        scan_idx_r <= (scan_idx_r == IDX_LAST) ? '0 : scan_idx_r + IW'(1);
      end else begin
        scan_cnt_r <= scan_cnt_r + SW'(1);
      end
      digit_sel <= sel_s;
      segments  <= blank_cur_s ? 7'h00 : seg_decode(cur_digit_s);
      dp        <= (scan_idx_r == '0) && (presc_r < TICK_HALF);
      if (load) begin
        count_bcd <= load_clamp_s;
        presc_r   <= '0;
        wrap      <= 1'b0;
      end else begin
        if (cnt_en) begin
          presc_r <= tick_s ? '0 : presc_r + PW'(1);
        end else begin
          presc_r <= presc_r;
        end
        if (event_s) begin
          count_bcd <= up ? inc_s : dec_s;
          wrap      <= up ? carry_s : borrow_s;
        end else begin
          wrap      <= 1'b0;
        end
      end
    end else begin
      wrap      <= 1'b0;
      segments  <= 7'h00;
      dp        <= 1'b0;
      digit_sel <= '0;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// Bench for seg7_bcd_scan_counter: directed steps plus random stimulus, checked
// every cycle against an integer-valued reference model of the counter and display.
module tb_seg7_bcd_scan_counter;
  localparam int D  = 4;
  localparam int TD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        cnt_en = 1'b0;
  logic        up = 1'b1;
  logic        step = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;

  logic [6:0]  a_seg, b_seg;
  logic        a_dp, b_dp, a_wrap, b_wrap;
  logic [3:0]  a_sel, b_sel;
  logic [15:0] a_count, b_count;

  int compared = 0;
  int mismatched = 0;

  int m_count, m_presc, m_scnt, m_idx, m_wrap, m_dp, m_sel, m_seg, m_seg_nb;
  int p10 [4] = '{1, 10, 100, 1000};
  logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0] exp_seq [8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8};

  seg7_bcd_scan_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cnt_en(cnt_en), .up(up), .step(step),
    .load(load), .load_value(load_value), .segments(a_seg), .dp(a_dp),
    .digit_sel(a_sel), .count_bcd(a_count), .wrap(a_wrap));

  seg7_bcd_scan_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cnt_en(cnt_en), .up(up), .step(step),
    .load(load), .load_value(load_value), .segments(b_seg), .dp(b_dp),
    .digit_sel(b_sel), .count_bcd(b_count), .wrap(b_wrap));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / p10[i]) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += ((b[4*i +: 4] > 4'd9) ? 9 : int'(b[4*i +: 4])) * p10[i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_scnt = 0; m_idx = 0;
    m_wrap = 0; m_dp = 0; m_sel = 0; m_seg = 0; m_seg_nb = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(a_count), 32'(to_bcd(m_count)));
    chk({tag, ".wrap"}, 32'(a_wrap), 32'(m_wrap));
    chk({tag, ".seg"}, 32'(a_seg), 32'(m_seg));
    chk({tag, ".dp"}, 32'(a_dp), 32'(m_dp));
    chk({tag, ".sel"}, 32'(a_sel), 32'(m_sel));
    chk({tag, ".seg_nolz"}, 32'(b_seg), 32'(m_seg_nb));
  endtask

  // One clock: predict from the pre-edge state and inputs, then compare after the edge
  task automatic cycle(input string tag);
    int n_count = m_count, n_presc = m_presc, n_scnt = m_scnt, n_idx = m_idx;
    int n_wrap = 0, n_dp = 0, n_sel = 0, n_seg = 0, n_seg_nb = 0;
    int digit;
    bit tick;
    if (ena) begin
      tick     = cnt_en && (m_presc == TD - 1);
      digit    = (m_count / p10[m_idx]) % 10;
      n_sel    = 1 << m_idx;
      n_seg_nb = int'(tbl[digit]);
      n_seg    = (m_idx != 0 && m_count < p10[m_idx]) ? 0 : int'(tbl[digit]);
      n_dp     = (m_idx == 0 && m_presc < TD / 2) ? 1 : 0;
      if (m_scnt == SD - 1) begin
        n_scnt = 0;
        n_idx  = (m_idx + 1) % D;
      end else begin
        n_scnt = m_scnt + 1;
      end
      if (load) begin
        n_count = from_load(load_value);
        n_presc = 0;
      end else begin
        if (cnt_en) n_presc = (m_presc + 1) % TD;
        if (tick || step) begin
          if (up) begin
            n_wrap  = (m_count == 9999) ? 1 : 0;
            n_count = (m_count + 1) % 10000;
          end else begin
            n_wrap  = (m_count == 0) ? 1 : 0;
            n_count = (m_count + 9999) % 10000;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    m_count = n_count; m_presc = n_presc; m_scnt = n_scnt; m_idx = n_idx;
    m_wrap = n_wrap; m_dp = n_dp; m_sel = n_sel; m_seg = n_seg; m_seg_nb = n_seg_nb;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    rst_n = 1'b1; ena = 1'b1; cnt_en = 1'b1; up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle("run40");
      if (i < 8) chk("scan_seq", 32'(a_sel), 32'(exp_seq[i]));
    end
    chk("count40", 32'(a_count), 32'h0010);

    load_value = 16'h9998; load = 1'b1;
    cycle("load9998");
    load = 1'b0;
    chk("load9998_val", 32'(a_count), 32'h9998);
    repeat (4) cycle("up_to_9999");
    chk("at9999", 32'(a_count), 32'h9999);
    repeat (4) cycle("up_wrap");
    chk("wrap_up_count", 32'(a_count), 32'h0000);
    chk("wrap_up_pulse", 32'(a_wrap), 32'h1);
    cycle("after_wrap");
    chk("wrap_single", 32'(a_wrap), 32'h0);

    load_value = 16'h0000; load = 1'b1; up = 1'b0;
    cycle("load0");
    load = 1'b0;
    repeat (4) cycle("down_wrap");
    chk("wrap_dn_count", 32'(a_count), 32'h9999);
    chk("wrap_dn_pulse", 32'(a_wrap), 32'h1);

    load_value = 16'h0A3F; load = 1'b1; up = 1'b1; cnt_en = 1'b0;
    cycle("clamp");
    load = 1'b0;
    chk("clamp_val", 32'(a_count), 32'h0939);

    repeat (3) begin
      step = 1'b1; cycle("step");
      step = 1'b0; cycle("step_gap");
    end
    chk("step3", 32'(a_count), 32'h0942);
    cnt_en = 1'b1;
    for (int k = 0; k < 8 && m_presc != TD - 1; k++) cycle("to_tick");
    step = 1'b1;
    cycle("step_tick");
    step = 1'b0;
    chk("step_tick_once", 32'(a_count), 32'h0943);

    load_value = 16'h9999; load = 1'b1;
    cycle("load9999");
    load = 1'b0;
    for (int k = 0; k < 8 && m_presc != TD - 1; k++) cycle("to_tick2");
    load_value = 16'h1234; load = 1'b1;
    cycle("load_vs_wrap");
    load = 1'b0;
    chk("load_wins_count", 32'(a_count), 32'h1234);
    chk("load_wins_nowrap", 32'(a_wrap), 32'h0);

    load_value = 16'h0007; load = 1'b1; cnt_en = 1'b0;
    cycle("load7");
    load = 1'b0;
    repeat (8) begin
      cycle("lz");
      chk("lz_seg", 32'(a_seg), (m_sel == 1) ? 32'h07 : 32'h00);
      chk("nolz_seg", 32'(b_seg), (m_sel == 1) ? 32'h07 : 32'h3F);
    end

    ena = 1'b0; cnt_en = 1'b1; step = 1'b1;
    repeat (10) cycle("ena_off");
    step = 1'b0;
    chk("off_seg", 32'(a_seg), 32'h0);
    chk("off_sel", 32'(a_sel), 32'h0);
    chk("off_count", 32'(a_count), 32'h0007);
    ena = 1'b1;

    for (int i = 0; i < 600; i++) begin
      ena        = ($urandom % 8) != 0;
      cnt_en     = ($urandom % 4) != 0;
      up         = $urandom % 2;
      step       = ($urandom % 6) == 0;
      load       = ($urandom % 25) == 0;
      load_value = 16'($urandom);
      cycle("rand");
    end
    load = 1'b0; step = 1'b0; ena = 1'b1; cnt_en = 1'b1;

    repeat (3) cycle("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    repeat (6) cycle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_scan_counter.md
Name: seg7_bcd_scan_counter

Overview:
- Parametrised successor to the single-digit seven-segment seconds counter.
- Holds a DIGITS-wide BCD counter advanced by a prescaled tick or a single-step strobe.
- Supports up/down counting and parallel load, and time-multiplexes the digits onto one shared segment bus with one-hot digit select.
- Sits directly behind the tt_um top-level pin mapping: segments to uo_out, digit select to uio_out.

Parameters:
- DIGITS, 4: number of BCD digits; 1..8.
- TICK_DIV, 10000000: enabled clock cycles per count tick; >= 2.
- SCAN_DIV, 1000: enabled clock cycles per digit scan slot; >= 1.
- BLANK_LZ, 1: 1 = leading-zero blanking on; 0 = all digits always shown.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable from the top level. 0 = freeze all state and blank the outputs.
- cnt_en  in  1  allows prescaler ticks to advance the count.
- up  in  1  count direction: 1 = up, 0 = down.
- step  in  1  one-cycle strobe; counts once regardless of cnt_en.
- load  in  1  synchronous parallel load.
- load_value  in  4*DIGITS  BCD load data; digit 0 = bits [3:0].
- segments  out  7  a..g on bits [0]..[6], active high, registered.
- dp  out  1  decimal point, registered.
- digit_sel  out  DIGITS  one-hot active-high digit enable, registered.
- count_bcd  out  4*DIGITS  current count, registered.
- wrap  out  1  one-cycle pulse on count wrap-around.

Behaviour:
- Reset (rst_n low, async): all outputs 0; count, prescaler, scan counter and scan index = 0.
- ena=0:
  - Prescaler, scan, count, load and step are all frozen/ignored.
  - segments, dp, digit_sel forced to 0 on the next edge; count_bcd holds.
  - Resuming ena=1 continues from the frozen state.
- Prescaler (ena=1):
  - Increments when cnt_en=1; holds when cnt_en=0.
  - At TICK_DIV-1 it wraps to 0 and asserts internal tick for that cycle.
- Count event: tick OR step. Simultaneous tick and step = exactly one event.
- Count priority, per cycle: load > event > hold.
  - load: count <= load_value; prescaler <= 0; wrap stays 0.
  - load: any digit >9 clamps to 9 per digit.
- Up event: BCD increment with ripple carry.
  - All-9s -> all-0s, with wrap=1 for the following cycle only.
- Down event: BCD decrement with ripple borrow.
  - All-0s -> all-9s, with wrap=1.
- count_bcd updates on the edge after the event (latency 1).
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 whenever ena=1.
  - On wrap, the scan index advances; it wraps DIGITS-1 -> 0.
  - Registered outputs reflect the current index and current count one cycle later.
  - First enabled cycle after reset: digit_sel = 1 (digit 0).
- Segment decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, bit0=a).
- Leading-zero blanking (BLANK_LZ=1):
  - A digit is blanked (segments=0, digit_sel still asserted) if it and all more-significant digits are 0.
  - Digit 0 is never blanked.
- dp = 1 only while digit 0 is selected AND prescaler < TICK_DIV/2 (half-rate blink); 0 otherwise.
- Reset asserted mid-count or mid-scan: immediate return to the reset state; no wrap pulse.
- Load during a wrap-generating event: load wins; no wrap.

Test Plan (DIGITS=4, TICK_DIV=4, SCAN_DIV=2, BLANK_LZ=1):
- Reset, then ena=1, cnt_en=1, up=1 for 40 cycles -> count_bcd = 0x0010 (one tick per 4 cycles); wrap never set; digit_sel sequence 1,1,2,2,4,4,8,8,…
- load=1 with 0x9998, then ticks up -> 9999, then 0000 with a single-cycle wrap=1; down from 0000 -> 9999 with wrap=1.
- load_value=0x0A3F -> count_bcd = 0x0939.
- cnt_en=0, step pulse on each of 3 separate cycles -> count +3. step on a tick cycle -> +1 only.
- Count 0x0007: digit_sel=1 -> segments=07; digit_sel=2/4/8 -> segments=00; with BLANK_LZ=0 they show 3F.
- ena=0 for 10 cycles -> segments=0, digit_sel=0, count held. Reset pulse mid-scan -> all outputs 0 asynchronously.
